// File: rtl/dpram_be_wseq_pkg.sv
// dpram_be_wseq_pkg: shared types and sizing helpers for the dpram_be write sequencer.
//   wseqState_e : sequencer state (StIdle, StWrite)
//   nByteOf     : number of byte lanes in a word
//   log2Ceil    : address / index width for a given depth (minimum 1)
package dpram_be_wseq_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } wseqState_e;

  function automatic int unsigned nByteOf(input int unsigned dataW, input int unsigned byteW);
    return dataW / byteW;
  endfunction

  function automatic int unsigned log2Ceil(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/dpram_be_lsb_pick.sv
// dpram_be_lsb_pick: lowest-set-bit priority encoder.
//   req    in  N     request vector
//   oneHot out N     one-hot of the lowest set bit of req (zero if req is zero)
//   idx    out IDXW  index of the lowest set bit (zero if req is zero)
//   vld    out 1     req has at least one bit set
module dpram_be_lsb_pick
  import dpram_be_wseq_pkg::*;
#(
  parameter int unsigned N = 10,
  localparam int unsigned IDXW = log2Ceil(N)
) (
  input  logic [N-1:0]    req,
  output logic [N-1:0]    oneHot,
  output logic [IDXW-1:0] idx,
  output logic            vld
);

  // Scan from the top down so the last hit, i.e. the lowest bit, wins.
  always_comb begin
    oneHot = '0;
    idx    = '0;
    vld    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        oneHot    = '0;
        oneHot[i] = 1'b1;
        idx       = IDXW'(i);
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_be_wseq.sv
// dpram_be_wseq: write sequencer and port-A arbiter in front of dpram_be.
//
// Accepts full-width masked word writes and serialises them into per-byte RAM
// writes on dpram_be port A (one BYTEW datum broadcast to all lanes, qualified by
// a lane-enable mask). Port A is shared with a full-width read channel; reads win
// arbitration in IDLE and are locked out while a word write is being serialised,
// so a port-A read never observes a partially written word.
//
// Build option: define DPRAM_BE_WSEQ_COALESCE_EN to let one write cycle cover every
// remaining enabled byte that carries the same value as the lowest pending byte.
// Without it each write cycle enables exactly one lane. Final RAM contents match.
//
// Ports:
//   clk      in   1      clock
//   rst      in   1      asynchronous active-low reset
//   wVld     in   1      word-write request valid
//   wRdy     out  1      word-write request ready
//   wAddr    in   ADDRW  word-write address
//   wData    in   DATAW  word-write data
//   wBe      in   NBYTE  word-write byte mask (zero is legal: consumed, no RAM write)
//   rVld     in   1      read request valid
//   rRdy     out  1      read request ready
//   rAddr    in   ADDRW  read address
//   rDv      out  1      read data valid, one cycle after read acceptance
//   rData    out  DATAW  read data (pass-through of ramRData)
//   busy     out  1      word write in progress
//   ramWEnb  out  1      dpram_be wEnbA
//   ramBEnb  out  NBYTE  dpram_be bEnbA
//   ramAddr  out  ADDRW  dpram_be addrA
//   ramWData out  BYTEW  dpram_be wDataA
//   ramRData in   DATAW  dpram_be rDataA
module dpram_be_wseq
  import dpram_be_wseq_pkg::*;
#(
  parameter int unsigned MEMD  = 1024,
  parameter int unsigned DATAW = 90,
  parameter int unsigned BYTEW = 9,
  localparam int unsigned NBYTE = nByteOf(DATAW, BYTEW),
  localparam int unsigned ADDRW = log2Ceil(MEMD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wVld,
  output logic             wRdy,
  input  logic [ADDRW-1:0] wAddr,
  input  logic [DATAW-1:0] wData,
  input  logic [NBYTE-1:0] wBe,
  input  logic             rVld,
  output logic             rRdy,
  input  logic [ADDRW-1:0] rAddr,
  output logic             rDv,
  output logic [DATAW-1:0] rData,
  output logic             busy,
  output logic             ramWEnb,
  output logic [NBYTE-1:0] ramBEnb,
  output logic [ADDRW-1:0] ramAddr,
  output logic [BYTEW-1:0] ramWData,
  input  logic [DATAW-1:0] ramRData
);

  localparam int unsigned IDXW = log2Ceil(NBYTE);

  wseqState_e       stateQ, stateD;
  logic [NBYTE-1:0] remQ, remD;
  logic [ADDRW-1:0] addrQ, addrD;
  logic [DATAW-1:0] dataQ, dataD;
  logic             rDvQ;

  logic [NBYTE-1:0] pickOneHot;
  logic [IDXW-1:0]  pickIdx;
  logic             pickVld;
  logic [BYTEW-1:0] pickByte;
  logic [NBYTE-1:0] writeMask;

  logic             idle;
  logic             readAcc;
  logic             writeAcc;

  dpram_be_lsb_pick #(
    .N (NBYTE)
  ) uPick (
    .req    (remQ),
    .oneHot (pickOneHot),
    .idx    (pickIdx),
    .vld    (pickVld)
  );

  // Byte value of the lowest pending lane; broadcast on ramWData.
  always_comb begin
    pickByte = '0;
    for (int j = 0; j < int'(NBYTE); j++) begin
      if (pickIdx == IDXW'(j)) begin
        pickByte = dataQ[j*BYTEW +: BYTEW];
      end
    end
  end

`ifdef DPRAM_BE_WSEQ_COALESCE_EN
  // Every pending lane holding the same value as the picked lane can share the
  // broadcast datum. The picked lane is OR-ed back in so progress never relies
  // on the comparator alone.
  logic [NBYTE-1:0] matchMask;

  always_comb begin
    matchMask = '0;
    for (int j = 0; j < int'(NBYTE); j++) begin
      matchMask[j] = (dataQ[j*BYTEW +: BYTEW] == pickByte);
    end
  end

  assign writeMask = (remQ & matchMask) | pickOneHot;
`else
  assign writeMask = pickOneHot;
`endif

  // Handshakes are gated by rst so both readies read low throughout reset.
  assign idle     = (stateQ == StIdle);
  assign rRdy     = rst & idle;
  assign wRdy     = rst & idle & ~rVld;
  assign readAcc  = rRdy & rVld;
  assign writeAcc = wRdy & wVld;

  assign busy  = (stateQ == StWrite);
  assign rDv   = rDvQ;
  assign rData = ramRData;

  always_comb begin
    stateD   = stateQ;
    remD     = remQ;
    addrD    = addrQ;
    dataD    = dataQ;
    ramWEnb  = 1'b0;
    ramBEnb  = '0;
    ramAddr  = '0;
    ramWData = '0;

    case (stateQ)
      StIdle: begin
        if (readAcc) begin
          ramAddr = rAddr;
        end else if (writeAcc) begin
          addrD = wAddr;
          dataD = wData;
          remD  = wBe;
          // An empty mask is consumed here without touching the RAM.
          if (wBe != '0) begin
            stateD = StWrite;
          end
        end
      end

      StWrite: begin
        ramWEnb  = pickVld;
        ramBEnb  = writeMask;
        ramAddr  = addrQ;
        ramWData = pickByte;
        remD     = remQ & ~writeMask;
        if (remD == '0) begin
          stateD = StIdle;
        end
      end

      default: begin
        stateD = StIdle;
        remD   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      remQ   <= '0;
      addrQ  <= '0;
      dataQ  <= '0;
      rDvQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      remQ   <= remD;
      addrQ  <= addrD;
      dataQ  <= dataD;
      rDvQ   <= readAcc;
    end
  end

endmodule

// File: tb/tb_dpram_be_wseq.sv
// tb_dpram_be_wseq: self-checking bench for dpram_be_wseq with a behavioural
// dpram_be port A attached. Read results are checked through a scoreboard queue
// filled from a reference memory when each read is accepted.
module tb_dpram_be_wseq;

  localparam int MEMD  = 1024;
  localparam int DATAW = 90;
  localparam int BYTEW = 9;
  localparam int NBYTE = 10;
  localparam int ADDRW = 10;

  logic             clk;
  logic             rst;
  logic             wVld;
  logic             wRdy;
  logic [ADDRW-1:0] wAddr;
  logic [DATAW-1:0] wData;
  logic [NBYTE-1:0] wBe;
  logic             rVld;
  logic             rRdy;
  logic [ADDRW-1:0] rAddr;
  logic             rDv;
  logic [DATAW-1:0] rData;
  logic             busy;
  logic             ramWEnb;
  logic [NBYTE-1:0] ramBEnb;
  logic [ADDRW-1:0] ramAddr;
  logic [BYTEW-1:0] ramWData;
  logic [DATAW-1:0] ramRData;

  dpram_be_wseq #(
    .MEMD  (MEMD),
    .DATAW (DATAW),
    .BYTEW (BYTEW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wVld     (wVld),
    .wRdy     (wRdy),
    .wAddr    (wAddr),
    .wData    (wData),
    .wBe      (wBe),
    .rVld     (rVld),
    .rRdy     (rRdy),
    .rAddr    (rAddr),
    .rDv      (rDv),
    .rData    (rData),
    .busy     (busy),
    .ramWEnb  (ramWEnb),
    .ramBEnb  (ramBEnb),
    .ramAddr  (ramAddr),
    .ramWData (ramWData),
    .ramRData (ramRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dpram_be port A: lane-masked broadcast write, registered read.
  bit   [DATAW-1:0] ramMem [MEMD];
  bit   [DATAW-1:0] refMem [MEMD];
  logic [DATAW-1:0] ramRDataR;
  assign ramRData = ramRDataR;

  always @(posedge clk) begin
    if (ramWEnb === 1'b1) begin
      for (int j = 0; j < NBYTE; j++) begin
        if (ramBEnb[j]) ramMem[ramAddr][j*BYTEW +: BYTEW] = ramWData;
      end
    end
    ramRDataR <= ramMem[ramAddr];
  end

  int               nRun;
  int               nFail;
  logic [DATAW-1:0] sbQ [$];
  logic [DATAW-1:0] monExp;

  // Scoreboard: a read pushed in one cycle must come back in the next.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      monExp = sbQ.pop_front();
      nRun++;
      if (rDv !== 1'b1 || rData !== monExp) begin
        nFail++;
        $display("FAIL read_data: rDv=%b rData=%h, required rDv=1 rData=%h", rDv, rData, monExp);
      end
    end else begin
      nRun++;
      if (rDv !== 1'b0) begin
        nFail++;
        $display("FAIL spurious_rdv: rDv=%b, required 0", rDv);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations collected by the drivers; the tests judge them.
  logic [NBYTE-1:0] obsBe   [$];
  logic [BYTEW-1:0] obsDat  [$];
  logic [ADDRW-1:0] obsAddr [$];
  int               obsBusyCyc;
  int               obsWenbIdle;
  bit               obsTimeout;

  task automatic drive_write(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d,
                             input logic [NBYTE-1:0] be);
    int n;
    obsBe.delete();
    obsDat.delete();
    obsAddr.delete();
    obsBusyCyc  = 0;
    obsWenbIdle = 0;
    obsTimeout  = 1'b0;
    @(negedge clk);
    wVld = 1'b1; wAddr = a; wData = d; wBe = be;
    #1;
    n = 0;
    while (wRdy !== 1'b1 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    if (wRdy !== 1'b1) obsTimeout = 1'b1;
    if (ramWEnb !== 1'b0) obsWenbIdle++;
    for (int j = 0; j < NBYTE; j++) begin
      if (be[j]) refMem[a][j*BYTEW +: BYTEW] = d[j*BYTEW +: BYTEW];
    end
    @(negedge clk);
    wVld = 1'b0; wBe = '0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      obsBusyCyc++;
      if (ramWEnb === 1'b1) begin
        obsBe.push_back(ramBEnb);
        obsDat.push_back(ramWData);
        obsAddr.push_back(ramAddr);
      end
      @(negedge clk); #1; n++;
    end
    if (busy !== 1'b0) obsTimeout = 1'b1;
    if (ramWEnb !== 1'b0) obsWenbIdle++;
  endtask

  task automatic drive_read(input logic [ADDRW-1:0] a);
    int n;
    obsTimeout = 1'b0;
    @(negedge clk);
    rVld = 1'b1; rAddr = a;
    #1;
    n = 0;
    while (rRdy !== 1'b1 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    if (rRdy !== 1'b1) obsTimeout = 1'b1;
    else sbQ.push_back(refMem[a]);
    @(negedge clk);
    rVld = 1'b0;
  endtask

  function automatic logic [DATAW-1:0] distinct_word(input int base);
    logic [DATAW-1:0] w;
    for (int j = 0; j < NBYTE; j++) w[j*BYTEW +: BYTEW] = BYTEW'(base + 7 * j);
    return w;
  endfunction

  // Write cycles a masked word should take.
  function automatic int exp_cycles(input logic [DATAW-1:0] d, input logic [NBYTE-1:0] be);
    int  c;
    bit  seen;
    c = 0;
    for (int i = 0; i < NBYTE; i++) begin
      if (be[i]) begin
`ifdef DPRAM_BE_WSEQ_COALESCE_EN
        seen = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (be[j] && d[j*BYTEW +: BYTEW] == d[i*BYTEW +: BYTEW]) seen = 1'b1;
        end
        if (!seen) c++;
`else
        seen = 1'b0;
        c += seen ? 0 : 1;
`endif
      end
    end
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    rVld = 1'b1; wVld = 1'b1; rAddr = 10'h155; wBe = '1;
    #1;
    nRun++;
    if ({rRdy, wRdy, busy, ramWEnb, rDv} !== 5'b0) begin
      nFail++;
      $display("FAIL reset_ctrl: rRdy,wRdy,busy,ramWEnb,rDv=%b, required 00000",
               {rRdy, wRdy, busy, ramWEnb, rDv});
    end
    nRun++;
    if (ramBEnb !== '0 || ramAddr !== '0 || ramWData !== '0) begin
      nFail++;
      $display("FAIL reset_ram: ramBEnb=%h ramAddr=%h ramWData=%h, required all 0",
               ramBEnb, ramAddr, ramWData);
    end
    rVld = 1'b0; wVld = 1'b0; wBe = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero_mask();
    drive_write(10'd5, distinct_word(3), 10'h000);
    nRun++;
    if (obsTimeout || obsBusyCyc != 0 || obsBe.size() != 0 || obsWenbIdle != 0) begin
      nFail++;
      $display("FAIL zero_mask: timeout=%0d busyCyc=%0d beats=%0d wenbIdle=%0d, required 0 0 0 0",
               obsTimeout, obsBusyCyc, obsBe.size(), obsWenbIdle);
    end
    drive_read(10'd5);
  endtask

  task automatic test_sparse();
    logic [NBYTE-1:0] expBe   [3] = '{10'h001, 10'h004, 10'h020};
    int               expLane [3] = '{0, 2, 5};
    logic [DATAW-1:0] d;
    drive_write(10'd3, distinct_word(9'h100), 10'h3FF);
    d = distinct_word(9'h040);
    drive_write(10'd3, d, 10'b0000100101);
    nRun++;
    if (obsTimeout || obsBusyCyc != 3 || obsBe.size() != 3) begin
      nFail++;
      $display("FAIL sparse_len: timeout=%0d busyCyc=%0d beats=%0d, required 0 3 3",
               obsTimeout, obsBusyCyc, obsBe.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (obsBe.size() > k) begin
        nRun++;
        if (obsBe[k] !== expBe[k] || obsDat[k] !== d[expLane[k]*BYTEW +: BYTEW] ||
            obsAddr[k] !== 10'd3) begin
          nFail++;
          $display("FAIL sparse_beat%0d: be=%h dat=%h addr=%0d, required be=%h dat=%h addr=3",
                   k, obsBe[k], obsDat[k], obsAddr[k], expBe[k], d[expLane[k]*BYTEW +: BYTEW]);
        end
      end
    end
    drive_read(10'd3);
  endtask

  task automatic test_full();
    drive_write(10'd9, distinct_word(9'h011), 10'h3FF);
    nRun++;
    if (obsTimeout || obsBusyCyc != 10 || obsBe.size() != 10) begin
      nFail++;
      $display("FAIL full_len: timeout=%0d busyCyc=%0d beats=%0d, required 0 10 10",
               obsTimeout, obsBusyCyc, obsBe.size());
    end
    for (int k = 0; k < obsBe.size(); k++) begin
      nRun++;
      if (obsBe[k] !== (NBYTE'(1) << k)) begin
        nFail++;
        $display("FAIL full_beat%0d: be=%h, required %h", k, obsBe[k], NBYTE'(1) << k);
      end
    end
    drive_read(10'd9);
  endtask

  task automatic test_coalesce();
    logic [DATAW-1:0] d;
    int               expCyc;
    logic [NBYTE-1:0] expBe0;
    for (int j = 0; j < NBYTE; j++) d[j*BYTEW +: BYTEW] = 9'h1AB;
`ifdef DPRAM_BE_WSEQ_COALESCE_EN
    expCyc = 1;  expBe0 = 10'h3FF;
`else
    expCyc = 10; expBe0 = 10'h001;
`endif
    drive_write(10'd11, d, 10'h3FF);
    nRun++;
    if (obsTimeout || obsBusyCyc != expCyc || obsBe.size() == 0) begin
      nFail++;
      $display("FAIL same_len: timeout=%0d busyCyc=%0d beats=%0d, required 0 %0d %0d",
               obsTimeout, obsBusyCyc, obsBe.size(), expCyc, expCyc);
    end else begin
      nRun++;
      if (obsBe[0] !== expBe0 || obsDat[0] !== 9'h1AB) begin
        nFail++;
        $display("FAIL same_beat0: be=%h dat=%h, required be=%h dat=1ab", obsBe[0], obsDat[0],
                 expBe0);
      end
    end
    drive_read(10'd11);
  endtask

  task automatic test_priority();
    logic [DATAW-1:0] d;
    int               n;
    int               leak;
    d = distinct_word(9'h0C0);
    @(negedge clk);
    rVld = 1'b1; rAddr = 10'd20;
    wVld = 1'b1; wAddr = 10'd20; wData = d; wBe = 10'b1000000011;
    #1;
    nRun++;
    if (rRdy !== 1'b1 || wRdy !== 1'b0) begin
      nFail++;
      $display("FAIL prio_both: rRdy=%b wRdy=%b, required 1 0", rRdy, wRdy);
    end
    sbQ.push_back(refMem[20]);
    @(negedge clk);
    rVld = 1'b0;
    #1;
    nRun++;
    if (wRdy !== 1'b1) begin
      nFail++;
      $display("FAIL prio_wnext: wRdy=%b, required 1", wRdy);
    end
    for (int j = 0; j < NBYTE; j++) begin
      if (wBe[j]) refMem[20][j*BYTEW +: BYTEW] = d[j*BYTEW +: BYTEW];
    end
    @(negedge clk);
    wVld = 1'b0; wBe = '0;
    rVld = 1'b1; rAddr = 10'd20;
    #1;
    nRun++;
    if (busy !== 1'b1 || rRdy !== 1'b0) begin
      nFail++;
      $display("FAIL prio_lock: busy=%b rRdy=%b, required 1 0", busy, rRdy);
    end
    n = 0; leak = 0;
    while (busy === 1'b1 && n < 30) begin
      if (rRdy !== 1'b0 || rDv !== 1'b0) leak++;
      @(negedge clk); #1; n++;
    end
    nRun++;
    if (leak != 0 || n != 3 || rRdy !== 1'b1) begin
      nFail++;
      $display("FAIL prio_wait: leaks=%0d busyCyc=%0d rRdy=%b, required 0 3 1", leak, n, rRdy);
    end
    sbQ.push_back(refMem[20]);
    @(negedge clk);
    rVld = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [ADDRW-1:0] addrs [4] = '{10'd3, 10'd9, 10'd11, 10'd20};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rVld = 1'b1; rAddr = addrs[k];
      #1;
      nRun++;
      if (rRdy !== 1'b1 || ramAddr !== addrs[k] || ramWEnb !== 1'b0) begin
        nFail++;
        $display("FAIL b2b_acc%0d: rRdy=%b ramAddr=%0d ramWEnb=%b, required 1 %0d 0",
                 k, rRdy, ramAddr, ramWEnb, addrs[k]);
      end
      sbQ.push_back(refMem[addrs[k]]);
    end
    @(negedge clk);
    rVld = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DATAW-1:0] d;
    d = distinct_word(9'h050);
    @(negedge clk);
    wVld = 1'b1; wAddr = 10'd30; wData = d; wBe = 10'b0101010010;
    #1;
    nRun++;
    if (wRdy !== 1'b1) begin
      nFail++;
      $display("FAIL rstmid_acc: wRdy=%b, required 1", wRdy);
    end
    @(negedge clk);
    wVld = 1'b0; wBe = '0;
    #1;
    nRun++;
    if (ramWEnb !== 1'b1 || ramBEnb !== 10'h002) begin
      nFail++;
      $display("FAIL rstmid_first: ramWEnb=%b ramBEnb=%h, required 1 002", ramWEnb, ramBEnb);
    end
    refMem[30][1*BYTEW +: BYTEW] = d[1*BYTEW +: BYTEW];
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    nRun++;
    if (ramWEnb !== 1'b0 || ramBEnb !== '0 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL rstmid_abort: ramWEnb=%b ramBEnb=%h busy=%b, required 0 000 0",
               ramWEnb, ramBEnb, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_read(10'd30);
    nRun++;
    if (obsTimeout) begin
      nFail++;
      $display("FAIL rstmid_read: read not accepted after reset, required accept");
    end
  endtask

  task automatic test_random();
    logic [95:0]      r96;
    logic [DATAW-1:0] d;
    logic [NBYTE-1:0] be;
    logic [ADDRW-1:0] a;
    int               expCyc;
    for (int it = 0; it < 100; it++) begin
      a = ADDRW'($urandom_range(40, 55));
      if ($urandom_range(0, 2) == 0) begin
        drive_read(a);
        nRun++;
        if (obsTimeout) begin
          nFail++;
          $display("FAIL rand_read%0d: timed out, required accept", it);
        end
      end else begin
        r96 = {$urandom(), $urandom(), $urandom()};
        d   = r96[DATAW-1:0];
        if ($urandom_range(0, 3) == 0) begin
          for (int j = 0; j < NBYTE; j++) begin
            if ($urandom_range(0, 1) == 0) d[j*BYTEW +: BYTEW] = d[BYTEW-1:0];
          end
        end
        be = NBYTE'($urandom_range(0, 1023));
        expCyc = exp_cycles(d, be);
        drive_write(a, d, be);
        nRun++;
        if (obsTimeout || obsBusyCyc != expCyc || obsBe.size() != expCyc) begin
          nFail++;
          $display("FAIL rand_write%0d: timeout=%0d busyCyc=%0d beats=%0d, required 0 %0d %0d",
                   it, obsTimeout, obsBusyCyc, obsBe.size(), expCyc, expCyc);
        end
      end
    end
    for (int k = 40; k <= 55; k++) drive_read(ADDRW'(k));
  endtask

  initial begin
    nRun  = 0;
    nFail = 0;
    wVld  = 1'b0; wAddr = '0; wData = '0; wBe = '0;
    rVld  = 1'b0; rAddr = '0;
    test_reset();
    test_zero_mask();
    test_sparse();
    test_full();
    test_coalesce();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    nRun++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("FAIL sb_drain: %0d reads outstanding, required 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
